// File: rtl/mult_pkg.sv
// Shared definitions for the sequential Booth multiplier.
//   state_e      : controller FSM states (IDLE, RUN, DONE)
//   booth_op_e   : datapath operation selected each RUN step (NOP, ADD, SUB)
//   booth_decode : maps the Booth pair {Q[0], q_1} to an operation
//   DEFAULT_WIDTH: default operand width
package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_e;

  // Radix-2 Booth recoding: 01 -> +M, 10 -> -M, 00/11 -> nothing.
  function automatic booth_op_e booth_decode(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// (WIDTH+1)-bit ripple-carry adder/subtractor.
//   x   : in  [WIDTH:0]  first operand
//   y   : in  [WIDTH:0]  second operand
//   sub : in  1          0 -> s = x + y, 1 -> s = x - y
//   s   : out [WIDTH:0]  result, wraps modulo 2^(WIDTH+1)
// Subtraction is x + ~y + 1: y is inverted by sub and sub is the carry-in.
module booth_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] x,
  input  logic [WIDTH:0] y,
  input  logic           sub,
  output logic [WIDTH:0] s
);

  logic [WIDTH:0] y_eff;
  logic [WIDTH:0] carry;

  assign y_eff    = y ^ {(WIDTH + 1){sub}};
  assign carry[0] = sub;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign s[i] = x[i] ^ y_eff[i] ^ carry[i];
    // The carry out of the top bit is dropped: results wrap.
    if (i < WIDTH) begin : g_carry
      assign carry[i + 1] = (x[i] & y_eff[i]) | (x[i] & carry[i]) | (y_eff[i] & carry[i]);
    end
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth signed multiplier. One shared (WIDTH+1)-bit
// add/subtract datapath is stepped WIDTH times to build the 2*WIDTH-bit
// two's-complement product.
//   clk       : in  1          rising-edge clock
//   rst       : in  1          synchronous reset, active-high
//   in_valid  : in  1          operand pair valid
//   in_ready  : out 1          block can accept operands (IDLE, not in reset)
//   a         : in  WIDTH      multiplicand, signed
//   b         : in  WIDTH      multiplier, signed
//   out_valid : out 1          product valid (DONE)
//   out_ready : in  1          consumer accepts product
//   product   : out 2*WIDTH    signed product a*b, held stable in DONE
//   state_o   : out state_e    current FSM state, for observation
//   zero, neg : out 1          product == 0 / product sign; only with
//                              BOOTH_MULT_FLAGS_EN defined
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready/valid driven by this block depend on the state register
// only (plus rst forcing in_ready low), never on the partner's signal.
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output state_e               state_o
`ifdef BOOTH_MULT_FLAGS_EN
  ,
  output logic                 zero,
  output logic                 neg
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH:0]       a_q, a_d;       // accumulator (upper product half)
  logic [WIDTH:0]       m_q, m_d;       // sign-extended multiplicand
  logic [WIDTH-1:0]     q_q, q_d;       // multiplier, shifts into lower half
  logic                 q1_q, q1_d;     // Booth look-behind bit
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
`ifdef BOOTH_MULT_FLAGS_EN
  logic                 zero_q, zero_d;
  logic                 neg_q, neg_d;
`endif

  // One Booth step: optional add/sub of M, then arithmetic shift right of
  // {A, Q, q_1}. The extra A bit keeps -M exact for the most-negative a.
  booth_op_e        op;
  logic             do_sub;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   a_sel;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] q_sh;
  logic             q1_sh;

  assign op     = booth_decode(q_q[0], q1_q);
  assign do_sub = (op == OP_SUB);

  booth_addsub #(.WIDTH(WIDTH)) u_addsub (
    .x   (a_q),
    .y   (m_q),
    .sub (do_sub),
    .s   (sum)
  );

  assign a_sel = (op == OP_NOP) ? a_q : sum;
  assign a_sh  = {a_sel[WIDTH], a_sel[WIDTH:1]};
  assign q_sh  = {a_sel[0], q_q[WIDTH-1:1]};
  assign q1_sh = q_q[0];

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
`ifdef BOOTH_MULT_FLAGS_EN
    zero_d    = zero_q;
    neg_d     = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = {a[WIDTH-1], a};
          a_d     = '0;
          q_d     = b;
          q1_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_sh;
        q_d   = q_sh;
        q1_d  = q1_sh;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          // Low 2*WIDTH bits of {A, Q} after the last shift hold the product.
          product_d = {a_sh[WIDTH-1:0], q_sh};
`ifdef BOOTH_MULT_FLAGS_EN
          zero_d    = ({a_sh[WIDTH-1:0], q_sh} == '0);
          neg_d     = a_sh[WIDTH-1];
`endif
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef BOOTH_MULT_FLAGS_EN
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
`ifdef BOOTH_MULT_FLAGS_EN
      zero_q    <= zero_d;
      neg_q     <= neg_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign product   = product_q;
  assign state_o   = state_q;
`ifdef BOOTH_MULT_FLAGS_EN
  assign zero      = zero_q;
  assign neg       = neg_q;
`endif

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;
  import mult_pkg::*;

  localparam int W = 8;

  // Directed extreme-value vectors and hand-computed products.
  localparam logic [W-1:0]   VA[6] = '{8'h80, 8'h80, 8'hFF, 8'h7F, 8'h80, 8'h00};
  localparam logic [W-1:0]   VB[6] = '{8'h80, 8'h7F, 8'h01, 8'h7F, 8'h01, 8'h80};
  localparam logic [2*W-1:0] VE[6] = '{16'h4000, 16'hC080, 16'hFFFF, 16'h3F01, 16'hFF80, 16'h0000};
  localparam logic [W-1:0]   CORN[5] = '{8'h00, 8'h01, 8'hFF, 8'h7F, 8'h80};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2*W-1:0]   product;
  state_e           state_o;
`ifdef BOOTH_MULT_FLAGS_EN
  logic             zero;
  logic             neg;
`endif

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .state_o   (state_o)
`ifdef BOOTH_MULT_FLAGS_EN
    ,
    .zero      (zero),
    .neg       (neg)
`endif
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, output bit to);
    int n;
    to = 1'b0;
    n = 0;
    a = av;
    b = bv;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) to = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit to);
    lat = 0;
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (out_valid === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (state_o !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_o, IDLE); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (product !== 16'h0000) begin errors++; $display("FAIL reset_product: got %h expected 0000", product); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %b expected 0", in_ready); end
`ifdef BOOTH_MULT_FLAGS_EN
    checks++;
    if ({zero, neg} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {zero, neg}); end
`endif
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    bit to1, to2;
    int lat;
    start_op(8'd3, 8'd5, to1);
    wait_done(lat, to2);
    checks++;
    if (to1 || to2) begin errors++; $display("FAIL basic_timeout: got %b%b expected 00", to1, to2); end
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d expected 8", lat); end
    checks++;
    if (product !== 16'h000F) begin errors++; $display("FAIL basic_product: got %h expected 000f", product); end
    checks++;
    if (state_o !== DONE) begin errors++; $display("FAIL basic_state_done: got %0d expected %0d", state_o, DONE); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_done: got %b expected 0", in_ready); end
    release_op();
    checks++;
    if (state_o !== IDLE) begin errors++; $display("FAIL basic_state_idle: got %0d expected %0d", state_o, IDLE); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_out_valid_drop: got %b expected 0", out_valid); end
  endtask

  task automatic test_extremes();
    bit to1, to2;
    int lat;
    for (int i = 0; i < 6; i++) begin
      start_op(VA[i], VB[i], to1);
      wait_done(lat, to2);
      checks++;
      if (to1 || to2) begin errors++; $display("FAIL extremes_timeout[%0d]: got %b%b expected 00", i, to1, to2); end
      checks++;
      if (product !== VE[i]) begin
        errors++;
        $display("FAIL extremes_product[%0d] a=%h b=%h: got %h expected %h", i, VA[i], VB[i], product, VE[i]);
      end
`ifdef BOOTH_MULT_FLAGS_EN
      checks++;
      if ({zero, neg} !== {(VE[i] == 16'h0000), VE[i][15]}) begin
        errors++;
        $display("FAIL extremes_flags[%0d]: got %b expected %b", i, {zero, neg}, {(VE[i] == 16'h0000), VE[i][15]});
      end
`endif
      release_op();
    end
  endtask

  task automatic test_backpressure();
    bit to1, to2;
    int lat;
    start_op(8'h07, 8'hFD, to1);   // 7 * -3 = -21
    wait_done(lat, to2);
    checks++;
    if (to1 || to2) begin errors++; $display("FAIL bp_timeout: got %b%b expected 00", to1, to2); end
    checks++;
    if (product !== 16'hFFEB) begin errors++; $display("FAIL bp_product: got %h expected ffeb", product); end
    // A second pair offered while DONE must be ignored.
    a = 8'd2;
    b = 8'd9;
    in_valid = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || product !== 16'hFFEB || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b p=%h r=%b expected v=1 p=ffeb r=0", i, out_valid, product, in_ready);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (state_o !== IDLE || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got state=%0d r=%b expected state=%0d r=1", state_o, in_ready, IDLE);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (state_o !== RUN) begin errors++; $display("FAIL bp_second_accept: got %0d expected %0d", state_o, RUN); end
    wait_done(lat, to2);
    checks++;
    if (to2 || lat !== 8) begin errors++; $display("FAIL bp_second_latency: got %0d (to=%b) expected 8", lat, to2); end
    checks++;
    if (product !== 16'h0012) begin errors++; $display("FAIL bp_second_product: got %h expected 0012", product); end
    release_op();
  endtask

  task automatic test_reset_mid_run();
    bit to1, to2;
    int lat;
    start_op(8'h64, 8'hCE, to1);   // 100 * -50
    tick();
    tick();
    tick();
    rst = 1'b1;                    // during the 4th RUN cycle
    tick();
    checks++;
    if (state_o !== IDLE || out_valid !== 1'b0 || product !== 16'h0000) begin
      errors++;
      $display("FAIL rst_run: got state=%0d v=%b p=%h expected state=%0d v=0 p=0000", state_o, out_valid, product, IDLE);
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_run_in_ready: got %b expected 0", in_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_run_in_ready_after: got %b expected 1", in_ready); end

    start_op(8'h64, 8'hCE, to1);
    wait_done(lat, to2);
    checks++;
    if (to1 || to2 || lat !== 8) begin errors++; $display("FAIL rst_rerun_latency: got %0d (to=%b%b) expected 8", lat, to1, to2); end
    checks++;
    if (product !== 16'hEC78) begin errors++; $display("FAIL rst_rerun_product: got %h expected ec78", product); end

    // Reset in DONE with both handshakes active: reset wins.
    in_valid = 1'b1;
    out_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (state_o !== IDLE || out_valid !== 1'b0 || product !== 16'h0000) begin
      errors++;
      $display("FAIL rst_done: got state=%0d v=%b p=%h expected state=%0d v=0 p=0000", state_o, out_valid, product, IDLE);
    end
`ifdef BOOTH_MULT_FLAGS_EN
    checks++;
    if ({zero, neg} !== 2'b00) begin errors++; $display("FAIL rst_done_flags: got %b expected 00", {zero, neg}); end
`endif
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]   pa[3];
    logic [W-1:0]   pb[3];
    logic [2*W-1:0] pe[3];
    int acc_cyc[3];
    int n_acc, n_out;
    bit acc;
    logic [2*W-1:0] e;
    pa = '{8'h05, 8'hF9, 8'h0C};
    pb = '{8'hFA, 8'hF7, 8'h0B};
    pe = '{16'hFFE2, 16'h003F, 16'h0084};   // -30, 63, 132
    n_acc = 0;
    n_out = 0;
    a = pa[0];
    b = pb[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      acc = (in_ready === 1'b1) && in_valid;
      if (out_valid === 1'b1) begin
        n_out++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected_output: got %h expected none", product);
        end else begin
          e = exp_q.pop_front();
          if (product !== e) begin errors++; $display("FAIL b2b_product: got %h expected %h", product, e); end
        end
      end
      if (acc) begin
        exp_q.push_back(pe[n_acc]);
        acc_cyc[n_acc] = cyc;
      end
      tick();
      if (acc) begin
        n_acc++;
        if (n_acc < 3) begin
          a = pa[n_acc];
          b = pb[n_acc];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    checks++;
    if (n_acc !== 3 || n_out !== 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_counts: got acc=%0d out=%0d left=%0d expected 3 3 0", n_acc, n_out, exp_q.size());
    end else begin
      checks++;
      if (acc_cyc[1] - acc_cyc[0] !== 10 || acc_cyc[2] - acc_cyc[1] !== 10) begin
        errors++;
        $display("FAIL b2b_interval: got %0d,%0d expected 10,10", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
      end
    end
  endtask

  task automatic test_random_sweep();
    bit to1, to2;
    int lat;
    logic signed [W-1:0]   sa, sb;
    logic signed [2*W-1:0] ex;
    for (int n = 0; n < 1025; n++) begin
      if (n < 25) begin
        sa = CORN[n / 5];
        sb = CORN[n % 5];
      end else begin
        sa = W'($urandom_range(255, 0));
        sb = W'($urandom_range(255, 0));
      end
      ex = sa * sb;
      start_op(sa, sb, to1);
      wait_done(lat, to2);
      checks++;
      if (to1 || to2 || product !== ex) begin
        errors++;
        $display("FAIL sweep_product a=%h b=%h: got %h (to=%b%b) expected %h", sa, sb, product, to1, to2, ex);
      end
`ifdef BOOTH_MULT_FLAGS_EN
      checks++;
      if ({zero, neg} !== {(ex == 0), ex[2*W-1]}) begin
        errors++;
        $display("FAIL sweep_flags a=%h b=%h: got %b expected %b", sa, sb, {zero, neg}, {(ex == 0), ex[2*W-1]});
      end
`endif
      release_op();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
